// File: rtl/ram_stream_reader_if.sv
// Bundle for ram_stream_reader: control, RAM read port, output stream.
// master = controller/RAM/consumer side, slave = the reader itself.
interface ram_stream_reader_if #(
  parameter int WIDTH   = 8,
  parameter int ENTRIES = 256
);
  localparam int AW = $clog2(ENTRIES);
  localparam int CW = $clog2(ENTRIES + 1);

  logic             start;
  logic [AW-1:0]    start_address;
  logic [CW-1:0]    count;
  logic             abort;
  logic             busy;
  logic             done;
  logic [AW-1:0]    ram_address;
  logic [WIDTH-1:0] ram_read_data;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output start, start_address, count, abort,
    output ram_read_data, out_ready,
    input  busy, done, ram_address,
    input  out_data, out_valid
  );

  modport slave (
    input  start, start_address, count, abort,
    input  ram_read_data, out_ready,
    output busy, done, ram_address,
    output out_data, out_valid
  );
endinterface

// File: rtl/ram_stream_reader.sv
// Reads count consecutive RAM words (1-cycle read latency) and streams
// them on valid/ready. Ports: clk, rst_n, bus (ram_stream_reader_if.slave).
module ram_stream_reader #(
  parameter int WIDTH   = 8,
  parameter int ENTRIES = 256
) (
  input logic                clk,
  input logic                rst_n,
  ram_stream_reader_if.slave bus
);
  localparam int AW = $clog2(ENTRIES);
  localparam int CW = $clog2(ENTRIES + 1);
  localparam logic [AW-1:0] LAST = AW'(ENTRIES - 1);
  localparam logic [CW-1:0] MAXC = CW'(ENTRIES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [CW-1:0]    remain_q, remain_d;
  logic [CW-1:0]    left_q, left_d;
  logic             inflight_q, inflight_d;
  logic [1:0]       occ_q, occ_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] buf_q [2];

  logic          flush;
  logic          pop;
  logic          push;
  logic          issue;
  logic [2:0]    outstanding;
  logic [CW-1:0] eff_cnt;
  logic [AW-1:0] addr_nxt;

  assign flush = bus.abort && (state_q != IDLE);
  assign pop   = (occ_q != 2'd0) && bus.out_ready;
  // Data returns the cycle after an issue; drop it on a cancel.
  assign push  = inflight_q && !flush;

  // Words already owed to the buffer after this cycle's pop.
  assign outstanding = {1'b0, occ_q}
                     + {2'b0, inflight_q}
                     - {2'b0, pop};

  assign issue = (state_q == READ)
              && (remain_q != '0)
              && (outstanding < 3'd2);

  assign eff_cnt  = (bus.count > MAXC) ? MAXC : bus.count;
  assign addr_nxt = (addr_q == LAST) ? '0 : addr_q + AW'(1);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    left_d     = left_q;
    inflight_d = inflight_q;
    occ_d      = occ_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (eff_cnt == '0) begin
            done_d = 1'b1;
          end else begin
            state_d  = READ;
            addr_d   = bus.start_address;
            remain_d = eff_cnt;
            left_d   = eff_cnt;
          end
        end
      end
      READ, DRAIN: begin
        if (flush) begin
          state_d    = IDLE;
          remain_d   = '0;
          left_d     = '0;
          inflight_d = 1'b0;
          occ_d      = 2'd0;
          wr_ptr_d   = 1'b0;
          rd_ptr_d   = 1'b0;
        end else begin
          inflight_d = issue;
          if (issue) begin
            addr_d   = addr_nxt;
            remain_d = remain_q - CW'(1);
            if (remain_q == CW'(1)) begin
              state_d = DRAIN;
            end
          end
          if (push) begin
            wr_ptr_d = ~wr_ptr_q;
          end
          if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            left_d   = left_q - CW'(1);
            if (left_q == CW'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
          occ_d = occ_q + {1'b0, push} - {1'b0, pop};
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      left_q     <= '0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      left_q     <= left_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      done_q     <= done_d;
    end
  end

  // Never overwrites an unread slot: issue keeps outstanding <= 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else if (push) begin
      buf_q[wr_ptr_q] <= bus.ram_read_data;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.ram_address = addr_q;
  assign bus.out_valid   = (occ_q != 2'd0);
  assign bus.out_data    = buf_q[rd_ptr_q];
endmodule

// File: tb/tb_ram_stream_reader.sv
// Randomized bench for ram_stream_reader against a queue-based model.
// Includes a behavioural RAM with 1-cycle read latency.
module tb_ram_stream_reader;
  localparam int WIDTH   = 8;
  localparam int ENTRIES = 16;
  localparam int AW      = $clog2(ENTRIES);
  localparam int CW      = $clog2(ENTRIES + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_stream_reader_if #(.WIDTH(WIDTH), .ENTRIES(ENTRIES)) bus ();

  ram_stream_reader #(.WIDTH(WIDTH), .ENTRIES(ENTRIES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [WIDTH-1:0] mem [ENTRIES];

  always @(posedge clk) bus.ram_read_data <= mem[bus.ram_address];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: pending words of the active transfer.
  bit               m_busy = 0;
  bit               m_done = 0;
  logic [WIDTH-1:0] q [$];
  int               m_sa, m_cnt, m_off, m_popped;
  logic [AW-1:0]    m_prev_addr = '0;
  bit               addr_known = 1;
  bit               prev_stall = 0;
  logic [WIDTH-1:0] prev_data;
  int               hs_count = 0;
  int               eff;
  bit               hs;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_data", bus.out_data, 0);
      chk("rst_addr", bus.ram_address, 0);
      m_busy = 0;
      m_done = 0;
      q.delete();
      prev_stall = 0;
      m_prev_addr = '0;
      addr_known = 1;
    end else begin
      chk("busy", bus.busy, m_busy);
      chk("done", bus.done, m_done);
      if (bus.out_valid) begin
        if (!m_busy || q.size() == 0)
          chk("valid_no_word", bus.out_valid, 0);
        else
          chk("data", bus.out_data, q[0]);
      end
      if (prev_stall) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_data", bus.out_data, prev_data);
      end
      if (m_busy) begin
        if (bus.ram_address != m_prev_addr) m_off++;
        chk("ram_addr", bus.ram_address, (m_sa + m_off) % ENTRIES);
        chk("outstanding_le2", (m_off - m_popped) <= 2, 1);
        chk("issued_le_count", m_off <= m_cnt, 1);
      end else if (addr_known) begin
        chk("addr_hold", bus.ram_address, m_prev_addr);
      end
      m_prev_addr = bus.ram_address;
      addr_known = 1;

      hs = bus.out_valid && bus.out_ready;
      if (hs) hs_count++;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
      m_done = 0;
      if (m_busy && bus.abort) begin
        m_busy = 0;
        q.delete();
        addr_known = 0;
        prev_stall = 0;
      end else if (m_busy) begin
        if (hs && q.size() > 0) begin
          void'(q.pop_front());
          m_popped++;
          if (q.size() == 0) begin
            m_busy = 0;
            m_done = 1;
          end
        end
      end else if (bus.start) begin
        eff = (int'(bus.count) > ENTRIES) ? ENTRIES : int'(bus.count);
        if (eff == 0) begin
          m_done = 1;
        end else begin
          m_busy = 1;
          m_sa = int'(bus.start_address);
          m_cnt = eff;
          m_off = 0;
          m_popped = 0;
          for (int i = 0; i < eff; i++)
            q.push_back(mem[(m_sa + i) % ENTRIES]);
          m_prev_addr = bus.start_address;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int sa, input int cnt);
    bus.start = 1'b1;
    bus.start_address = AW'(sa);
    bus.count = CW'(cnt);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (bus.busy && n < budget) begin
      tick();
      n++;
    end
    chk("idle_timeout", bus.busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    bit pat [7];
    pat = '{1, 0, 0, 1, 1, 0, 1};
    bus.start = 0;
    bus.start_address = '0;
    bus.count = '0;
    bus.abort = 0;
    bus.out_ready = 0;
    for (int i = 0; i < ENTRIES; i++) mem[i] = WIDTH'(3 * i + 1);

    #3;
    chk("por_busy", bus.busy, 0);
    chk("por_valid", bus.out_valid, 0);
    chk("por_addr", bus.ram_address, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    // Basic read: 7,10,13,16
    bus.out_ready = 1;
    do_start(2, 4);
    chk("b_busy", bus.busy, 1);
    chk("b_addr0", bus.ram_address, 2);
    chk("b_nv0", bus.out_valid, 0);
    tick();
    chk("b_nv1", bus.out_valid, 0);
    tick();
    chk("b_v", bus.out_valid, 1);
    chk("b_d0", bus.out_data, 7);
    tick();
    chk("b_d1", bus.out_data, 10);
    tick();
    chk("b_d2", bus.out_data, 13);
    tick();
    chk("b_d3", bus.out_data, 16);
    tick();
    chk("b_done", bus.done, 1);
    chk("b_idle", bus.busy, 0);

    // Start in the done cycle, with address wrap
    do_start(14, 4);
    chk("w_a0", bus.ram_address, 14);
    tick();
    chk("w_a1", bus.ram_address, 15);
    tick();
    chk("w_a2", bus.ram_address, 0);
    chk("w_d0", bus.out_data, 43);
    tick();
    chk("w_a3", bus.ram_address, 1);
    chk("w_d1", bus.out_data, 46);
    tick();
    chk("w_d2", bus.out_data, 1);
    tick();
    chk("w_d3", bus.out_data, 4);
    tick();
    chk("w_done", bus.done, 1);
    tick();

    // Saturating count
    base = hs_count;
    do_start(5, 20);
    wait_idle(100);
    chk("sat_words", hs_count - base, 16);
    tick();

    // Zero count
    do_start(3, 0);
    chk("z_done", bus.done, 1);
    chk("z_busy", bus.busy, 0);
    for (int i = 0; i < 5; i++) begin
      chk("z_novalid", bus.out_valid, 0);
      tick();
    end

    // Start while busy is ignored
    base = hs_count;
    do_start(0, 6);
    tick();
    bus.start = 1;
    bus.start_address = AW'(9);
    bus.count = CW'(3);
    tick();
    bus.start = 0;
    wait_idle(100);
    chk("busy_start_words", hs_count - base, 6);
    tick();
    chk("busy_start_idle", bus.busy, 0);

    // Fixed backpressure pattern
    base = hs_count;
    do_start(4, 8);
    n = 0;
    while (bus.busy && n < 100) begin
      bus.out_ready = pat[n % 7];
      tick();
      n++;
    end
    chk("bp_words", hs_count - base, 8);
    chk("bp_timeout", bus.busy, 0);

    // Random backpressure
    base = hs_count;
    do_start(11, 8);
    n = 0;
    while (bus.busy && n < 100) begin
      bus.out_ready = ($urandom % 2) == 0;
      tick();
      n++;
    end
    chk("rbp_words", hs_count - base, 8);
    chk("rbp_timeout", bus.busy, 0);

    // Abort after 2 of 6 words
    bus.out_ready = 1;
    base = hs_count;
    do_start(0, 6);
    n = 0;
    while ((hs_count - base) < 2 && n < 20) begin
      tick();
      n++;
    end
    bus.out_ready = 0;
    bus.abort = 1;
    tick();
    bus.abort = 0;
    chk("ab_valid", bus.out_valid, 0);
    chk("ab_busy", bus.busy, 0);
    chk("ab_done0", bus.done, 0);
    tick();
    chk("ab_done1", bus.done, 0);
    bus.out_ready = 1;
    base = hs_count;
    do_start(8, 3);
    wait_idle(50);
    chk("ab_restart", hs_count - base, 3);

    // Reset mid-transfer
    do_start(0, 6);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mr_busy", bus.busy, 0);
    chk("mr_done", bus.done, 0);
    chk("mr_valid", bus.out_valid, 0);
    chk("mr_data", bus.out_data, 0);
    chk("mr_addr", bus.ram_address, 0);
    tick();
    rst_n = 1'b1;
    tick();
    base = hs_count;
    do_start(2, 4);
    wait_idle(50);
    chk("mr_restart", hs_count - base, 4);

    // Random transfers
    for (int t = 0; t < 60; t++) begin
      wait_idle(200);
      for (int i = 0; i < ENTRIES; i++) mem[i] = WIDTH'($urandom);
      do_start($urandom_range(0, ENTRIES - 1), $urandom_range(0, 20));
      n = 0;
      while (bus.busy && n < 300) begin
        bus.out_ready = ($urandom % 4) != 0;
        bus.abort = ($urandom % 40) == 0;
        bus.start = ($urandom % 12) == 0;
        bus.start_address = AW'($urandom);
        bus.count = CW'($urandom_range(0, 20));
        if (($urandom % 300) == 0) begin
          #2 rst_n = 1'b0;
          tick();
          rst_n = 1'b1;
        end else begin
          tick();
        end
        n++;
      end
      bus.abort = 0;
      bus.start = 0;
      tick();
    end
    wait_idle(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
